// File: rtl/fsk_pkg.sv
// Shared constants for the FSK phase-control slice: register map, CTRL bits
// and the 5-bit x^5+x^3+1 LFSR step.
package fsk_pkg;

    localparam logic [1:0] ADDR_INC0   = 2'd0;
    localparam logic [1:0] ADDR_INC1   = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RESYNC = 2'd3;

    localparam int CTRL_RUN_BIT = 0;
    localparam int CTRL_FSK_BIT = 1;

    localparam int LFSR_W      = 5;
    localparam int LFSR_TAP_A  = 0;
    localparam int LFSR_TAP_B  = 2;

    // Fibonacci step: feedback enters at the MSB, register shifts right.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_TAP_A] ^ q[LFSR_TAP_B], q[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/fsk_lfsr.sv
// 5-bit Fibonacci LFSR with step and reseed; shared with the downstream modulator.
module fsk_lfsr
    import fsk_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              reseed,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_q;

    // Reseed wins over step so a resync never advances the sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= seed;
        end else if (reseed) begin
            r_q <= seed;
        end else if (step) begin
            r_q <= lfsr_next(r_q);
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/fsk_phase_ctrl.sv
// DDS control stage: symbol timer, LFSR modulation bit, and shadow/active
// phase increments that switch atomically on symbol boundaries.
module fsk_phase_ctrl
    import fsk_pkg::*;
#(
    parameter int unsigned         PHASE_W   = 32,
    parameter int unsigned         SYM_DIV   = 50000000,
    parameter logic [LFSR_W-1:0]   LFSR_SEED = 5'b00001,
    parameter logic [PHASE_W-1:0]  INC0_RST  = 32'd171800,
    parameter logic [PHASE_W-1:0]  INC1_RST  = 32'd343600
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_wr,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic [PHASE_W-1:0] phase_inc,
    output logic               dds_en,
    output logic               sym_tick,
    output logic               mod_bit,
    output logic [LFSR_W-1:0]  lfsr_q
);

    localparam int unsigned      CNT_W    = $clog2(SYM_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_DIV - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;
    logic               r_fsk;
    logic [PHASE_W-1:0] r_sh0;
    logic [PHASE_W-1:0] r_sh1;
    logic [PHASE_W-1:0] r_act0;
    logic [PHASE_W-1:0] r_act1;
    logic [PHASE_W-1:0] r_phase;
    logic               r_tick;
    logic [31:0]        r_rdata;

    logic               w_wr_inc0;
    logic               w_wr_inc1;
    logic               w_wr_ctrl;
    logic               w_resync;
    logic               w_wrap;
    logic               w_load;
    logic               w_q0_next;
    logic [PHASE_W-1:0] w_act0_next;
    logic [PHASE_W-1:0] w_act1_next;
    logic [PHASE_W-1:0] w_phase_next;
    logic [31:0]        w_rdata;
    logic [LFSR_W-1:0]  w_lfsr_q;

    assign w_wr_inc0 = cfg_wr && (cfg_addr == ADDR_INC0);
    assign w_wr_inc1 = cfg_wr && (cfg_addr == ADDR_INC1);
    assign w_wr_ctrl = cfg_wr && (cfg_addr == ADDR_CTRL);
    assign w_resync  = cfg_wr && (cfg_addr == ADDR_RESYNC);
    assign w_wrap    = r_run && (r_cnt == CNT_LAST) && !w_resync;
    assign w_load    = w_wrap || !r_run;

    // Active copies load from the registered shadow, so a same-edge write lands one symbol later.
    assign w_act0_next = w_load ? r_sh0 : r_act0;
    assign w_act1_next = w_load ? r_sh1 : r_act1;
    // After a step the new q[0] is the old q[1], since the register shifts right.
    assign w_q0_next   = w_resync ? LFSR_SEED[0] : (w_wrap ? w_lfsr_q[1] : w_lfsr_q[0]);
    assign w_phase_next = (r_fsk && w_q0_next) ? w_act1_next : w_act0_next;

    fsk_lfsr u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .step   (w_wrap),
        .reseed (w_resync),
        .seed   (LFSR_SEED),
        .q      (w_lfsr_q)
    );

    // Symbol counter: held at zero while stopped, cleared by resync.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_resync || !r_run || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Bus-writable registers: CTRL and the two shadow increments.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run <= 1'b0;
            r_fsk <= 1'b0;
            r_sh0 <= INC0_RST;
            r_sh1 <= INC1_RST;
        end else begin
            if (w_wr_ctrl) begin
                r_run <= cfg_wdata[CTRL_RUN_BIT];
                r_fsk <= cfg_wdata[CTRL_FSK_BIT];
            end
            if (w_wr_inc0) begin
                r_sh0 <= cfg_wdata[PHASE_W-1:0];
            end
            if (w_wr_inc1) begin
                r_sh1 <= cfg_wdata[PHASE_W-1:0];
            end
        end
    end

    // Active increments, output increment and symbol pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_act0  <= INC0_RST;
            r_act1  <= INC1_RST;
            r_phase <= INC0_RST;
            r_tick  <= 1'b0;
        end else begin
            r_act0  <= w_act0_next;
            r_act1  <= w_act1_next;
            r_phase <= w_load ? w_phase_next : r_phase;
            r_tick  <= w_wrap;
        end
    end

    // Read-back mux.
    always_comb begin
        w_rdata = 32'd0;
        case (cfg_addr)
            ADDR_INC0:   w_rdata = 32'(r_sh0);
            ADDR_INC1:   w_rdata = 32'(r_sh1);
            ADDR_CTRL:   w_rdata = {30'd0, r_fsk, r_run};
            ADDR_RESYNC: w_rdata = {27'd0, w_lfsr_q};
            default:     w_rdata = 32'd0;
        endcase
    end

    // Registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'd0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign cfg_rdata = r_rdata;
    assign phase_inc = r_phase;
    assign dds_en    = r_run;
    assign sym_tick  = r_tick;
    assign mod_bit   = w_lfsr_q[0];
    assign lfsr_q    = w_lfsr_q;

endmodule

// File: tb/tb_fsk_phase_ctrl.sv
// Scoreboard bench for fsk_phase_ctrl with SYM_DIV=4: stimulus queues expected
// tick/snapshot/read responses, a negedge monitor pops and compares them.
module tb_fsk_phase_ctrl;

    localparam logic [31:0] I0 = 32'd171800;
    localparam logic [31:0] I1 = 32'd343600;

    logic        clk;
    logic        reset;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic [31:0] phase_inc;
    logic        dds_en;
    logic        sym_tick;
    logic        mod_bit;
    logic [4:0]  lfsr_q;

    fsk_phase_ctrl #(
        .PHASE_W   (32),
        .SYM_DIV   (4),
        .LFSR_SEED (5'b00001),
        .INC0_RST  (32'd171800),
        .INC1_RST  (32'd343600)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .phase_inc (phase_inc),
        .dds_en    (dds_en),
        .sym_tick  (sym_tick),
        .mod_bit   (mod_bit),
        .lfsr_q    (lfsr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          tick_cnt = 0;
    logic [36:0] tick_q[$];
    logic [39:0] snap_q[$];
    string       snap_nm[$];
    logic [31:0] rd_q[$];
    logic        snap_req = 1'b0;
    logic        rd_issue = 1'b0;
    logic        rd_valid = 1'b0;
    logic        done = 1'b0;
    logic        done_seen = 1'b0;

    always @(posedge clk) rd_valid <= rd_issue;

    // Monitor: every comparison in the bench happens here.
    always @(negedge clk) begin
        logic [36:0] te;
        logic [39:0] se;
        logic [31:0] re;
        string       nm;
        if (sym_tick) begin
            tick_cnt++;
            checks++;
            if (tick_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick got lfsr=%b phase=%0d expected no tick", lfsr_q, phase_inc);
            end else begin
                te = tick_q.pop_front();
                if ({lfsr_q, mod_bit, phase_inc} !== {te[36:32], te[32], te[31:0]}) begin
                    errors++;
                    $display("FAIL tick%0d got lfsr=%b mod=%b phase=%0d expected lfsr=%b mod=%b phase=%0d",
                             tick_cnt, lfsr_q, mod_bit, phase_inc, te[36:32], te[32], te[31:0]);
                end
            end
        end
        if (snap_req) begin
            se = snap_q.pop_front();
            nm = snap_nm.pop_front();
            checks++;
            if ({phase_inc, dds_en, sym_tick, lfsr_q, mod_bit} !== se) begin
                errors++;
                $display("FAIL %s got phase=%0d en=%b tick=%b lfsr=%b mod=%b expected phase=%0d en=%b tick=%b lfsr=%b mod=%b",
                         nm, phase_inc, dds_en, sym_tick, lfsr_q, mod_bit,
                         se[39:8], se[7], se[6], se[5:1], se[0]);
            end
        end
        if (rd_valid) begin
            re = rd_q.pop_front();
            checks++;
            if (cfg_rdata !== re) begin
                errors++;
                $display("FAIL read got rdata=%0d expected %0d", cfg_rdata, re);
            end
        end
        if (done && !done_seen) begin
            done_seen = 1'b1;
            checks++;
            if (tick_q.size() != 0) begin
                errors++;
                $display("FAIL missing_ticks got %0d outstanding expected 0", tick_q.size());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp);
        cfg_addr = a;
        rd_q.push_back(exp);
        rd_issue = 1'b1;
        @(posedge clk); #1;
        rd_issue = 1'b0;
    endtask

    task automatic snap(input string nm, input logic [31:0] ph, input logic en,
                        input logic tk, input logic [4:0] lq);
        snap_q.push_back({ph, en, tk, lq, lq[0]});
        snap_nm.push_back(nm);
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
    endtask

    task automatic push_tick(input logic [4:0] lq, input logic [31:0] ph);
        tick_q.push_back({lq, ph});
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 400; i++) begin
            if (tick_cnt >= target) break;
            @(posedge clk); #1;
        end
        if (tick_cnt < target) begin
            $display("FAIL tick_timeout got %0d ticks expected %0d", tick_cnt, target);
            $fatal(1, "tick timeout");
        end
    endtask

    initial begin
        logic [4:0] m;
        int         base;
        reset = 1'b1; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state, idle with run=0, register read-back.
        snap("reset_state", I0, 1'b0, 1'b0, 5'b00001);
        cyc(6);
        rd(2'd0, I0);
        rd(2'd1, I1);
        rd(2'd2, 32'd0);
        rd(2'd3, 32'd1);

        // run=1, fsk=1: first five ticks hand-computed, then full period.
        wr(2'd2, 32'd3);
        snap("run_enable", I0, 1'b1, 1'b0, 5'b00001);
        base = tick_cnt;
        push_tick(5'b10000, I0);
        push_tick(5'b01000, I0);
        push_tick(5'b00100, I0);
        push_tick(5'b10010, I0);
        push_tick(5'b01001, I1);
        m = 5'b01001;
        for (int i = 6; i <= 30; i++) begin
            m = {m[0] ^ m[2], m[4:1]};
            push_tick(m, m[0] ? I1 : I0);
        end
        push_tick(5'b00001, I1);
        wait_until(base + 31);

        // Mid-symbol INC1 write shows only at the next tick.
        base = tick_cnt;
        push_tick(5'b10000, I0);
        push_tick(5'b01000, I0);
        push_tick(5'b00100, I0);
        push_tick(5'b10010, I0);
        wait_until(base + 4);
        wr(2'd1, 32'd500000);
        snap("inc1_midsym_hold", I0, 1'b1, 1'b0, 5'b10010);
        base = tick_cnt;
        push_tick(5'b01001, 32'd500000);
        push_tick(5'b10100, I0);
        push_tick(5'b11010, I0);
        wait_until(base + 3);

        // INC1 write on the wrap edge: old value now, new value a symbol later.
        base = tick_cnt;
        push_tick(5'b01101, 32'd500000);
        push_tick(5'b00110, I0);
        push_tick(5'b10011, 32'd600000);
        cyc(2);
        wr(2'd1, 32'd600000);
        wait_until(base + 3);

        // fsk=0: inc0 only, LFSR keeps stepping, INC0 write at next symbol.
        wr(2'd2, 32'd1);
        base = tick_cnt;
        push_tick(5'b11001, I0);
        wait_until(base + 1);
        wr(2'd0, 32'd1000);
        snap("inc0_midsym_hold", I0, 1'b1, 1'b0, 5'b11001);
        base = tick_cnt;
        push_tick(5'b11100, 32'd1000);
        push_tick(5'b11110, 32'd1000);
        wait_until(base + 2);
        rd(2'd3, 32'd30);

        // Resync mid-symbol: seed restored, next tick exactly 4 cycles later.
        push_tick(5'b10000, 32'd1000);
        wr(2'd3, 32'd0);
        snap("resync_c0", 32'd1000, 1'b1, 1'b0, 5'b00001);
        snap("resync_c1", 32'd1000, 1'b1, 1'b0, 5'b00001);
        snap("resync_c2", 32'd1000, 1'b1, 1'b0, 5'b00001);
        snap("resync_c3", 32'd1000, 1'b1, 1'b0, 5'b00001);
        snap("resync_c4", 32'd1000, 1'b1, 1'b1, 5'b10000);

        // Reset mid-symbol with a write in flight: write is discarded.
        cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'd777; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; cfg_wr = 1'b0;
        snap("midsym_reset", I0, 1'b0, 1'b0, 5'b00001);
        rd(2'd0, I0);
        rd(2'd2, 32'd0);
        cyc(8);

        // run=0: phase_inc follows shadow with one cycle of latency.
        wr(2'd2, 32'd2);
        wr(2'd1, 32'd4242);
        snap("idle_follow_old", I1, 1'b0, 1'b0, 5'b00001);
        snap("idle_follow_new", 32'd4242, 1'b0, 1'b0, 5'b00001);
        rd(2'd1, 32'd4242);
        rd(2'd2, 32'd2);
        rd(2'd3, 32'd1);

        done = 1'b1;
        cyc(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsk_phase_ctrl.md
Name: fsk_phase_ctrl

Overview:
Upstream control stage for the DDS waveform generator (waveform_gen). It produces the generator's phase_inc and en inputs, and holds a 5-bit LFSR that supplies the modulation bit. In FSK mode it switches phase_inc between two programmed increments on every symbol boundary. The CPU bus writes shadow registers, which are applied atomically at the next symbol tick, so the DDS never sees a torn increment.

Parameters:
PHASE_W, 32, width of the phase increment (matches waveform_gen phase_inc).
SYM_DIV, 50000000, clk cycles per symbol (1 Hz at 50 MHz); minimum 2.
LFSR_SEED, 5'b00001, LFSR reset/reseed value; must be nonzero.
INC0_RST, 32'd171800, reset value of increment 0 (shadow and active).
INC1_RST, 32'd343600, reset value of increment 1 (shadow and active).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
cfg_wr  in  1  single-cycle write strobe.
cfg_addr  in  2  register select: 0=INC0, 1=INC1, 2=CTRL, 3=RESYNC/LFSR.
cfg_wdata  in  32  write data.
cfg_rdata  out  32  read data, registered, valid 1 cycle after cfg_addr.
phase_inc  out  PHASE_W  increment to waveform_gen.
dds_en  out  1  enable to waveform_gen.
sym_tick  out  1  one-cycle pulse, first cycle of each new symbol.
mod_bit  out  1  current modulation bit (lfsr[0]).
lfsr_q  out  5  current LFSR state.

Behaviour:
- Reset values:
  - counter=0, lfsr=LFSR_SEED, mod_bit=LFSR_SEED[0], sym_tick=0.
  - CTRL: run=0, fsk=0.
  - shadow/active inc0=INC0_RST, inc1=INC1_RST.
  - phase_inc=INC0_RST, dds_en=0, cfg_rdata=0.
  - Reset mid-operation: every register returns to these values at the next edge; an in-flight write is discarded.
- CTRL layout: bit0=run, bit1=fsk. Writes take effect immediately. dds_en = registered run (1 cycle after the write).
- Writes to addr 0/1 update only the shadow register.
- Symbol counter, run=1:
  - Counts 0..SYM_DIV-1, then wraps to 0.
  - At the edge where counter==SYM_DIV-1, all of the following happen on that same edge:
    - LFSR steps: new = q[0]^q[2]; q <= {new, q[4:1]} (x^5+x^3+1, period 31).
    - active inc0/inc1 <= shadow.
    - phase_inc <= fsk ? (next_q[0] ? shadow inc1 : shadow inc0) : shadow inc0.
    - sym_tick is high during the following cycle, together with the new mod_bit and phase_inc.
- run=0:
  - Counter held at 0, LFSR frozen, sym_tick=0.
  - Active registers track shadow every cycle.
  - phase_inc follows the same select rule with 1-cycle latency from a write.
- Write to a shadow on the same cycle as a wrap edge: the active register gets the OLD shadow value; the new value applies at the following symbol.
- Write to addr 3: counter<=0, lfsr<=LFSR_SEED, no sym_tick. This has priority over a simultaneous wrap.
- fsk=0: phase_inc=active inc0. The LFSR still steps on each symbol, so mod_bit remains valid for downstream ASK/BPSK.
- Reads, valid next cycle:
  - addr 0/1 return shadow inc0/inc1.
  - addr 2 returns {30'b0, fsk, run}.
  - addr 3 returns {27'b0, lfsr}.
- Counter width: $clog2(SYM_DIV). All arithmetic is unsigned; there is no overflow path.

Decomposition:
- Shared package fsk_pkg:
  - address constants ADDR_INC0..ADDR_RESYNC.
  - CTRL bit indices.
  - LFSR_W=5 and tap positions.
- One sub-module, fsk_lfsr:
  - Inputs: clk, reset, step, reseed, seed.
  - Output: q.
  - Pure 5-bit Fibonacci LFSR, reused by the downstream modulator.

Test Plan:
- Reset, SYM_DIV=4 -> phase_inc=171800, dds_en=0, lfsr_q=00001, mod_bit=1, sym_tick never pulses while run=0.
- Write CTRL=3 -> dds_en=1 next cycle. Successive sym_tick every 4 cycles gives lfsr_q 10000, 01000, 00100, 10010, 01001, mod_bit 0,0,0,0,1. phase_inc alternates 171800/343600 per mod_bit on the same cycle as sym_tick. Period 31 verified.
- run=1: write INC1=500000 mid-symbol -> phase_inc unchanged until the next sym_tick; write coincident with the wrap edge -> applied one symbol later.
- fsk=0, run=1 -> phase_inc constant at active inc0; lfsr still steps; write INC0=1000 shows at the next symbol only.
- Write addr 3 mid-symbol -> lfsr_q=00001, next sym_tick exactly 4 cycles later; assert reset mid-symbol -> all outputs at reset values after one edge.
- Read each addr -> cfg_rdata returns the shadow, CTRL, or LFSR value one cycle after cfg_addr.
